// File: rtl/gate_pkg.sv
// Op-code types and single-bit gate evaluators shared by the gate-array pipeline.
// Functions work on one bit so any operand width can be built by replication.
package gate_pkg;

  localparam int OP1_W = 3;
  localparam int OP2_W = 2;

  typedef enum logic [OP1_W-1:0] {
    OP1_AND    = 3'd0,
    OP1_OR     = 3'd1,
    OP1_XOR    = 3'd2,
    OP1_NAND   = 3'd3,
    OP1_NOR    = 3'd4,
    OP1_XNOR   = 3'd5,
    OP1_PASS_A = 3'd6,
    OP1_NOT_A  = 3'd7
  } op1_e;

  typedef enum logic [OP2_W-1:0] {
    OP2_AND  = 2'd0,
    OP2_OR   = 2'd1,
    OP2_XOR  = 2'd2,
    OP2_PASS = 2'd3
  } op2_e;

  function automatic logic gate_fn(op1_e op, logic a, logic b);
    logic r;
    case (op)
      OP1_AND:    r = a & b;
      OP1_OR:     r = a | b;
      OP1_XOR:    r = a ^ b;
      OP1_NAND:   r = ~(a & b);
      OP1_NOR:    r = ~(a | b);
      OP1_XNOR:   r = ~(a ^ b);
      OP1_PASS_A: r = a;
      default:    r = ~a;
    endcase
    return r;
  endfunction

  function automatic logic gate2_fn(op2_e op, logic x, logic d);
    logic r;
    case (op)
      OP2_AND: r = x & d;
      OP2_OR:  r = x | d;
      OP2_XOR: r = x ^ d;
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_lane.sv
// One channel of combinational gate evaluation: out1 = op1(a,b), out2 = op2(out1,d).
module gate_lane
  import gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  input  logic [OP1_W-1:0] op1,
  input  logic [OP2_W-1:0] op2,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2
);

  op1_e op1_sel;
  op2_e op2_sel;

  assign op1_sel = op1_e'(op1);
  assign op2_sel = op2_e'(op2);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic r1;
    assign r1       = gate_fn(op1_sel, a[gi], b[gi]);
    assign out1[gi] = r1;
    assign out2[gi] = gate2_fn(op2_sel, r1, d[gi]);
  end

endmodule

// File: rtl/gate_array_pipe.sv
// CH-channel gate array with a STAGES-deep bubble-collapsing valid/ready pipeline
// and a saturating count of completed output transfers.
module gate_array_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CH     = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*WIDTH-1:0]   a,
  input  logic [CH*WIDTH-1:0]   b,
  input  logic [CH*WIDTH-1:0]   d,
  input  logic [CH*OP1_W-1:0]   op1,
  input  logic [CH*OP2_W-1:0]   op2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*WIDTH-1:0]   out1,
  output logic [CH*WIDTH-1:0]   out2,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam int DW = CH * WIDTH;

  logic [DW-1:0]     res1;
  logic [DW-1:0]     res2;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] v_q, v_d;
  logic [DW-1:0]     o1_q [STAGES];
  logic [DW-1:0]     o1_d [STAGES];
  logic [DW-1:0]     o2_q [STAGES];
  logic [DW-1:0]     o2_d [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    gate_lane #(.WIDTH(WIDTH)) u_lane (
      .a    (a[gi*WIDTH +: WIDTH]),
      .b    (b[gi*WIDTH +: WIDTH]),
      .d    (d[gi*WIDTH +: WIDTH]),
      .op1  (op1[gi*OP1_W +: OP1_W]),
      .op2  (op2[gi*OP2_W +: OP2_W]),
      .out1 (res1[gi*WIDTH +: WIDTH]),
      .out2 (res2[gi*WIDTH +: WIDTH])
    );
  end

  // Stage i is blocked only when it and every stage after it hold data and the
  // output is stalled; flattening the recurrence keeps the enables chain-free.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_en
    assign en[gi] = out_ready || !(&v_q[STAGES-1:gi]);
  end

  assign xfer      = v_q[STAGES-1] && out_ready;
  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign out1      = o1_q[STAGES-1];
  assign out2      = o2_q[STAGES-1];
  assign xfer_cnt  = cnt_q;

  always_comb begin
    v_d     = v_q;
    o1_d[0] = o1_q[0];
    o2_d[0] = o2_q[0];
    if (en[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        o1_d[0] = res1;
        o2_d[0] = res2;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      o1_d[i] = o1_q[i];
      o2_d[i] = o2_q[i];
      if (en[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          o1_d[i] = o1_q[i-1];
          o2_d[i] = o2_q[i-1];
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        o1_q[i] <= '0;
        o2_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        o1_q[i] <= o1_d[i];
        o2_q[i] <= o2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_gate_array_pipe.sv
// Bench for gate_array_pipe: three builds (STAGES=2/CNT_W=8, STAGES=1/CNT_W=2, STAGES=4)
// share one stimulus; each has its own scoreboard and transfer-count model.
module tb_gate_array_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       cnt_clr;
  logic [7:0] a, b, d;
  logic [5:0] op1;
  logic [3:0] op2;

  logic [2:0] ir;
  logic [2:0] ov;
  logic [7:0] o1w [3];
  logic [7:0] o2w [3];
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_array_pipe #(.WIDTH(4), .CH(2), .STAGES(2), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .d(d), .op1(op1), .op2(op2),
    .out_valid(ov[0]), .out_ready(out_ready), .out1(o1w[0]), .out2(o2w[0]),
    .cnt_clr(cnt_clr), .xfer_cnt(cnt0)
  );

  gate_array_pipe #(.WIDTH(4), .CH(2), .STAGES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .d(d), .op1(op1), .op2(op2),
    .out_valid(ov[1]), .out_ready(out_ready), .out1(o1w[1]), .out2(o2w[1]),
    .cnt_clr(cnt_clr), .xfer_cnt(cnt1)
  );

  gate_array_pipe #(.WIDTH(4), .CH(2), .STAGES(4), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .d(d), .op1(op1), .op2(op2),
    .out_valid(ov[2]), .out_ready(out_ready), .out1(o1w[2]), .out2(o2w[2]),
    .cnt_clr(cnt_clr), .xfer_cnt(cnt2)
  );

  // Reference model: returns {out2, out1} for both channels.
  function automatic logic [15:0] model(logic [7:0] aa, logic [7:0] bb, logic [7:0] dd,
                                        logic [5:0] o1, logic [3:0] o2);
    logic [7:0] r1, r2;
    logic [3:0] x, y, z, p;
    r1 = '0;
    r2 = '0;
    for (int c = 0; c < 2; c++) begin
      x = aa[c*4 +: 4];
      y = bb[c*4 +: 4];
      z = dd[c*4 +: 4];
      case (o1[c*3 +: 3])
        3'd0:    p = x & y;
        3'd1:    p = x | y;
        3'd2:    p = x ^ y;
        3'd3:    p = ~(x & y);
        3'd4:    p = ~(x | y);
        3'd5:    p = ~(x ^ y);
        3'd6:    p = x;
        default: p = ~x;
      endcase
      r1[c*4 +: 4] = p;
      case (o2[c*2 +: 2])
        2'd0:    r2[c*4 +: 4] = p & z;
        2'd1:    r2[c*4 +: 4] = p | z;
        2'd2:    r2[c*4 +: 4] = p ^ z;
        default: r2[c*4 +: 4] = p;
      endcase
    end
    return {r2, r1};
  endfunction

  // Per-build scoreboard: push on accept, pop on transfer, track expected count.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    localparam int MAXC = (gi == 1) ? 3 : 255;
    logic [15:0] sbq [$];
    logic [15:0] exp_v;
    logic [7:0]  cur_cnt;
    int          exp_cnt = 0;
    int          pops = 0;

    assign cur_cnt = (gi == 0) ? cnt0 : (gi == 1) ? {6'd0, cnt1} : cnt2;

    initial begin
      forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
          sbq.delete();
          exp_cnt = 0;
        end else begin
          n_checks++;
          if (cur_cnt !== exp_cnt[7:0]) begin
            n_fail++;
            $display("FAIL sb_cnt dut%0d: xfer_cnt=%0d required=%0d", gi, cur_cnt, exp_cnt);
          end
          if (ov[gi] && out_ready) begin
            n_checks++;
            if (sbq.size() == 0) begin
              n_fail++;
              $display("FAIL sb_extra dut%0d: unexpected beat out1=%h out2=%h required=none",
                       gi, o1w[gi], o2w[gi]);
            end else begin
              exp_v = sbq.pop_front();
              if ({o2w[gi], o1w[gi]} !== exp_v) begin
                n_fail++;
                $display("FAIL sb_data dut%0d: out2/out1=%h/%h required=%h/%h",
                         gi, o2w[gi], o1w[gi], exp_v[15:8], exp_v[7:0]);
              end else begin
                $display("dut%0d xfer out1=%h out2=%h", gi, o1w[gi], o2w[gi]);
              end
            end
            pops++;
          end
          if (in_valid && ir[gi]) sbq.push_back(model(a, b, d, op1, op2));
          if (cnt_clr) exp_cnt = 0;
          else if (ov[gi] && out_ready && exp_cnt < MAXC) exp_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [7:0] aa, logic [7:0] bb, logic [7:0] dd,
                       logic [5:0] o1, logic [3:0] o2);
    a = aa; b = bb; d = dd; op1 = o1; op2 = o2;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    if (ov !== 3'b000) begin n_fail++; $display("FAIL rst_valid: out_valid=%b required=000", ov); end
    n_checks++;
    if (o1w[0] !== 8'h00 || o2w[0] !== 8'h00) begin
      n_fail++; $display("FAIL rst_data: out1=%h out2=%h required=00/00", o1w[0], o2w[0]);
    end
    n_checks++;
    if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: xfer_cnt=%0d required=0", cnt0); end
    n_checks++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    if (ir !== 3'b111) begin n_fail++; $display("FAIL rst_in_ready: in_ready=%b required=111", ir); end
    n_checks++;
  endtask

  task automatic test_basic();
    step();
    drive(8'hF0, 8'hFF, 8'h0F, 6'b000_000, 4'b01_00);
    step();
    in_valid = 1'b0;
    step();
    if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid: out_valid=%b required=1", ov[0]); end
    n_checks++;
    if (o1w[0] !== 8'hF0 || o2w[0] !== 8'hF0) begin
      n_fail++; $display("FAIL basic_data: out1=%h out2=%h required=f0/f0", o1w[0], o2w[0]);
    end
    n_checks++;
    step();
    if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: xfer_cnt=%0d required=1", cnt0); end
    n_checks++;
  endtask

  task automatic test_op_sweep();
    logic [3:0] tbl [8];
    logic [2:0] sel;
    tbl = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};
    for (int j = 0; j < 10; j++) begin
      step();
      if (j < 8) begin
        sel = j[2:0];
        drive(8'h0C, 8'h0A, 8'h06, {3'd0, sel}, 4'b10_10);
      end else begin
        in_valid = 1'b0;
      end
      if (j >= 2) begin
        if (ov[0] !== 1'b1 || o1w[0][3:0] !== tbl[j-2] || o2w[0][3:0] !== (tbl[j-2] ^ 4'b0110)) begin
          n_fail++;
          $display("FAIL sweep_op%0d: valid=%b out1=%h out2=%h required=1/%h/%h",
                   j-2, ov[0], o1w[0][3:0], o2w[0][3:0], tbl[j-2], tbl[j-2] ^ 4'b0110);
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_backpressure();
    repeat (6) step();
    out_ready = 1'b0;
    cnt_clr   = 1'b1;
    drive(8'h01, 8'h00, 8'h00, 6'b110_110, 4'b11_11);
    if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: in_ready=%b required=1", ir[0]); end
    n_checks++;
    step();
    cnt_clr = 1'b0;
    drive(8'h02, 8'h00, 8'h00, 6'b110_110, 4'b11_11);
    if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: in_ready=%b required=1", ir[0]); end
    n_checks++;
    step();
    drive(8'h03, 8'h00, 8'h00, 6'b110_110, 4'b11_11);
    for (int k = 0; k < 4; k++) begin
      if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || o1w[0] !== 8'h01) begin
        n_fail++;
        $display("FAIL bp_hold%0d: in_ready=%b valid=%b out1=%h required=0/1/01", k, ir[0], ov[0], o1w[0]);
      end
      n_checks++;
      step();
    end
    out_ready = 1'b1;
    #1;
    if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready=%b required=1", ir[0]); end
    n_checks++;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    if (cnt0 !== 8'd3) begin n_fail++; $display("FAIL bp_cnt: xfer_cnt=%0d required=3", cnt0); end
    n_checks++;
    if (g_mon[0].sbq.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: pending=%0d required=0", g_mon[0].sbq.size());
    end
    n_checks++;
  endtask

  task automatic test_counter();
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int j = 0; j < 5; j++) begin
      drive(8'(j * 17), 8'h5A, 8'h3C, 6'b001_010, 4'b00_01);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    if (cnt1 !== 2'd3) begin n_fail++; $display("FAIL cnt_sat: xfer_cnt=%0d required=3", cnt1); end
    n_checks++;
    if (cnt0 !== 8'd5 || cnt2 !== 8'd5) begin
      n_fail++; $display("FAIL cnt_five: xfer_cnt=%0d/%0d required=5/5", cnt0, cnt2);
    end
    n_checks++;
    drive(8'hA5, 8'h33, 8'hF0, 6'b011_100, 4'b10_00);
    step();
    in_valid = 1'b0;
    if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_setup: out_valid=%b required=1", ov[1]); end
    n_checks++;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL cnt_clr_prio: xfer_cnt=%0d required=0", cnt1); end
    n_checks++;
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 8'h33, 6'b010_010, 4'b01_01);
    step();
    drive(8'h44, 8'h55, 8'h66, 6'b101_101, 4'b10_10);
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    if (ov !== 3'b000 || o1w[0] !== 8'h00 || o2w[0] !== 8'h00 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: valid=%b out1=%h out2=%h cnt=%0d required=000/00/00/0",
               ov, o1w[0], o2w[0], cnt0);
    end
    n_checks++;
    #1 rst_n = 1'b1;
    step();
    if (ir !== 3'b111) begin n_fail++; $display("FAIL midrst_ready: in_ready=%b required=111", ir); end
    n_checks++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ov !== 3'b000) begin n_fail++; $display("FAIL midrst_stale%0d: out_valid=%b required=000", k, ov); end
      n_checks++;
    end
  endtask

  task automatic test_latency();
    int lat [3];
    int want [3];
    want = '{1, 0, 3};
    lat  = '{-1, -1, -1};
    step();
    drive(8'h96, 8'h69, 8'hC3, 6'b111_000, 4'b11_10);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      for (int x = 0; x < 3; x++) if (ov[x] && lat[x] < 0) lat[x] = k;
    end
    for (int x = 0; x < 3; x++) begin
      if (lat[x] != want[x]) begin
        n_fail++; $display("FAIL latency_dut%0d: cycles=%0d required=%0d", x, lat[x], want[x]);
      end
      n_checks++;
    end
  endtask

  task automatic test_back_to_back();
    int p0 [3];
    for (int x = 0; x < 3; x++) p0[x] = 0;
    repeat (4) step();
    p0[0] = g_mon[0].pops;
    p0[1] = g_mon[1].pops;
    p0[2] = g_mon[2].pops;
    for (int j = 0; j < 16; j++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 6'($urandom), 4'($urandom));
      if (ir !== 3'b111) begin n_fail++; $display("FAIL b2b_ready%0d: in_ready=%b required=111", j, ir); end
      n_checks++;
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();
    if (g_mon[0].pops - p0[0] != 16 || g_mon[1].pops - p0[1] != 16 || g_mon[2].pops - p0[2] != 16) begin
      n_fail++;
      $display("FAIL b2b_count: beats=%0d/%0d/%0d required=16/16/16",
               g_mon[0].pops - p0[0], g_mon[1].pops - p0[1], g_mon[2].pops - p0[2]);
    end
    n_checks++;
    if (g_mon[0].sbq.size() + g_mon[1].sbq.size() + g_mon[2].sbq.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: beats still pending, required none");
    end
    n_checks++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    a = '0; b = '0; d = '0; op1 = '0; op2 = '0;
    test_reset();
    test_basic();
    test_op_sweep();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_latency();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 3-input gate cells. CH independent channels, each WIDTH bits wide; per-channel runtime selection of the primary and secondary gate functions.
- Inputs and op-codes are carried through STAGES register stages with valid/ready flow control.
- A saturating counter tracks completed output transfers.
- Sits between the stimulus/config front end and downstream result checkers in the gate-lab datapath.

Parameters:
- WIDTH, 4, bits per operand per channel (>=1)
- CH, 2, number of independent channels (>=1)
- STAGES, 2, pipeline register stages (1..4)
- CNT_W, 8, width of the transfer counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  CH*WIDTH  operand A, channel c at bits [c*WIDTH +: WIDTH]
- b  in  CH*WIDTH  operand B, same packing
- d  in  CH*WIDTH  operand D, same packing
- op1  in  CH*3  primary op per channel
- op2  in  CH*2  secondary op per channel
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out1  out  CH*WIDTH  primary result op1(a,b)
- out2  out  CH*WIDTH  secondary result op2(out1,d)
- cnt_clr  in  1  synchronous clear of xfer_cnt
- xfer_cnt  out  CNT_W  completed out transfers, saturating

Behaviour:
- Reset: rst_n low immediately clears every stage valid bit and all data registers. While in reset, out_valid=0, out1=0, out2=0, xfer_cnt=0. in_ready=1 as soon as rst_n is released.
- op1 encoding, bitwise, per channel:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 A (pass a), 7 NOT A
- op2 encoding, applied to out1 and d:
  - 0 AND, 1 OR, 2 XOR, 3 PASS (out2=out1)
- Compute and registering:
  - Functions are evaluated combinationally on the input beat.
  - out1/out2 are written into stage 0 at the accepting edge.
  - Stages 1..STAGES-1 are pure delay.
- Handshake:
  - An input beat is accepted on a rising edge when in_valid && in_ready.
  - An output transfer occurs on a rising edge when out_valid && out_ready.
  - in_valid/data need not be held stable once accepted. out1/out2/out_valid must remain stable while out_valid && !out_ready.
- Flow control (bubble-collapsing):
  - Stage i advances when en[i] = !v[i] || en[i+1].
  - Last stage: en[last] = !out_valid || out_ready.
  - in_ready = en[0], which is combinational from out_ready. No combinational path from in_valid to in_ready.
- Latency: a beat accepted at edge k appears on out_* after edge k+STAGES-1 when there is no backpressure. STAGES=1 gives a result visible right after the accepting edge.
- Throughput: 1 beat/cycle with out_ready held high.
- Full pipeline with out_ready=0:
  - in_ready=0 and no beat is lost.
  - Empty stages behind a stalled stage still fill.
- Simultaneous accept and transfer on a full pipe: both occur in the same edge and occupancy is unchanged.
- Ordering: beats exit strictly in acceptance order. Channels never interact.
- xfer_cnt:
  - +1 per output transfer; saturates at 2^CNT_W-1 and holds there.
  - cnt_clr has priority: if cnt_clr and a transfer share an edge, xfer_cnt=0.
- Reset mid-operation drops all in-flight beats; nothing is replayed after release.
- Unused op codes: none; all encodings are defined.

Decomposition:
- Package gate_pkg:
  - typedef enum logic[2:0] op1_e
  - typedef enum logic[1:0] op2_e
  - localparam encodings
  - function gate_fn(op1_e, a, b), width-generic via WIDTH-sized typedef in module scope or let-style helper
- Sub-module gate_lane: one channel's combinational op1/op2 evaluation, instantiated CH times via generate.
- Pipeline registers, flow control and counter stay in the top module.

Test Plan:
- Default params. Ch0 a=0000,b=1111,d=1111,op1=AND,op2=AND; ch1 a=1111,b=1111,d=0000,op1=AND,op2=OR; out_ready=1 -> after 1 cycle out_valid=1, ch0 out1=0000 out2=0000, ch1 out1=1111 out2=1111, xfer_cnt=1.
- Op sweep ch0 a=1100,b=1010,d=0110, op1 0..7 with op2=XOR -> out1 = 1000,1110,0110,0111,0001,1001,1100,0011 respectively; out2 = out1^0110 each beat. Back-to-back, one result per cycle, in order.
- Backpressure: out_ready=0, drive 3 beats -> 2 accepted, in_ready=0 on third, out1 held stable. Raise out_ready -> all 3 emerge in order, xfer_cnt=3.
- Counter: CNT_W=2, 5 transfers -> xfer_cnt=3 (saturated). Assert cnt_clr coincident with a transfer -> xfer_cnt=0.
- Reset mid-flight: 2 beats in pipe, pulse rst_n low between edges -> out_valid=0, out1=0, xfer_cnt=0 immediately. After release in_ready=1 and no stale beats appear.
- STAGES=1 and STAGES=4 builds: measure accept-to-out_valid as 0 and 3 cycles; full-throughput stream of 16 beats with zero loss.
